// File: rtl/hydra_pkg.sv
// Shared types for the hydra switch ingress path: header/descriptor layouts,
// the ingress FSM state encoding and a saturating counter helper.
package hydra_pkg;

  localparam int HDR_PORT_BITS = 4;
  localparam int HDR_PRIO_BITS = 3;
  localparam int HDR_LEN_BITS  = 9;

  // Header word layout at default widths, MSB first: {len, prio, dest}.
  typedef struct packed {
    logic [HDR_LEN_BITS-1:0]  len;
    logic [HDR_PRIO_BITS-1:0] prio;
    logic [HDR_PORT_BITS-1:0] dest;
  } hdr_t;

  typedef struct packed {
    logic [HDR_PORT_BITS-1:0] dest;
    logic [HDR_PRIO_BITS-1:0] prio;
    logic [HDR_LEN_BITS-1:0]  len;
  } desc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2
  } state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ingress_sram.sv
// Simple dual-port data buffer: one write port, one read port with a
// registered output (data appears the cycle after re).
module ingress_sram #(
  parameter int DEPTH     = 512,
  parameter int WIDTH     = 17,
  parameter int ADDR_BITS = 9
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ingress_port_buffer.sv
// Per-port ingress front-end: parses {len, prio, dest} headers, buffers payload
// and commits only complete, length-correct packets. Optional: INGRESS_STATS_EN.
module ingress_port_buffer
  import hydra_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int PORT_BITS    = 4,
  parameter int PRIO_BITS    = 3,
  parameter int LEN_BITS     = 9,
  parameter int DEPTH        = 512,
  parameter int DESC_DEPTH   = 16,
  parameter int PAUSE_THRESH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_sop,
  input  logic                  wr_vld,
  input  logic                  wr_eop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  pause,
  output logic                  desc_vld,
  input  logic                  desc_rdy,
  output logic [PORT_BITS-1:0]  desc_dest,
  output logic [PRIO_BITS-1:0]  desc_prio,
  output logic [LEN_BITS-1:0]   desc_len,
  input  logic                  rd_req,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic [1:0]            fsm_state
`ifdef INGRESS_STATS_EN
  ,
  output logic [31:0]           stat_pkt,
  output logic [31:0]           stat_drop
`endif
);

  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = AW + 1;
  localparam int DAW    = $clog2(DESC_DEPTH);
  localparam int DESC_W = LEN_BITS + PRIO_BITS + PORT_BITS;

  localparam logic [PW-1:0]  DEPTH_P   = PW'(DEPTH);
  localparam logic [PW-1:0]  THRESH_P  = PW'(PAUSE_THRESH);
  localparam logic [DAW:0]   DESC_FULL = (DAW+1)'(DESC_DEPTH);
  localparam logic [DAW:0]   DESC_HI   = (DAW+1)'(DESC_DEPTH - 1);

  // Write-side state.
  state_t               state;
  logic [LEN_BITS-1:0]  hdr_len;
  logic [PRIO_BITS-1:0] hdr_prio;
  logic [PORT_BITS-1:0] hdr_dest;
  logic [LEN_BITS-1:0]  cnt;
  logic                 ovf;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        commit_ptr;
  logic [PW-1:0]        pkt_start_ptr;
  logic [PW-1:0]        rd_ptr;

  // Descriptor FIFO.
  logic [DESC_W-1:0]    desc_mem [DESC_DEPTH];
  logic [DAW:0]         desc_wp;
  logic [DAW:0]         desc_rp;
  logic [DAW:0]         desc_cnt;
  logic                 desc_full;
  logic [DESC_W-1:0]    desc_head;

  logic [PW-1:0]        used;
  logic [PW-1:0]        free_words;
  logic                 buf_full;
  logic                 body_wr;
  logic                 wr_ok;
  logic [LEN_BITS-1:0]  cnt_nxt;
  logic                 ovf_nxt;
  logic                 commit;
  logic                 drop_eop;
  logic                 abort;
  logic                 word_last;
  logic                 rd_acc;
  logic                 desc_pop;
  logic                 rd_vld_q;
  logic [DATA_WIDTH:0]  sram_q;

  // Buffer occupancy counts every written word, committed or still pending.
  assign used       = wr_ptr - rd_ptr;
  assign free_words = DEPTH_P - used;
  assign buf_full   = (used == DEPTH_P);

  assign body_wr   = (state == BODY) && !wr_sop && wr_vld;
  assign wr_ok     = body_wr && !buf_full && !(&cnt);
  assign cnt_nxt   = cnt + {{(LEN_BITS-1){1'b0}}, wr_ok};
  assign ovf_nxt   = ovf | (body_wr & ~wr_ok);
  assign word_last = ((cnt + {{(LEN_BITS-1){1'b0}}, 1'b1}) == hdr_len);

  assign desc_cnt  = desc_wp - desc_rp;
  assign desc_full = (desc_cnt == DESC_FULL);

  assign commit   = (state == BODY) && !wr_sop && wr_eop &&
                    (cnt_nxt == hdr_len) && !ovf_nxt && !desc_full;
  assign drop_eop = !wr_sop && wr_eop &&
                    ((state == HDR) || ((state == BODY) && !commit));
  assign abort    = wr_sop && (state != IDLE);

  assign rd_acc   = rd_req && (rd_ptr != commit_ptr);
  assign desc_vld = (desc_cnt != '0);
  assign desc_pop = desc_vld && desc_rdy;

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      hdr_len       <= '0;
      hdr_prio      <= '0;
      hdr_dest      <= '0;
      cnt           <= '0;
      ovf           <= 1'b0;
      wr_ptr        <= '0;
      commit_ptr    <= '0;
      pkt_start_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (wr_sop) begin
        state <= HDR;
        if (abort && (state == BODY)) wr_ptr <= pkt_start_ptr;
      end else begin
        unique case (state)
          IDLE: ;
          HDR: begin
            if (drop_eop) begin
              state <= IDLE;
            end else if (wr_vld) begin
              hdr_dest      <= wr_data[PORT_BITS-1:0];
              hdr_prio      <= wr_data[PORT_BITS +: PRIO_BITS];
              hdr_len       <= wr_data[PORT_BITS+PRIO_BITS +: LEN_BITS];
              cnt           <= '0;
              ovf           <= 1'b0;
              pkt_start_ptr <= wr_ptr;
              state         <= BODY;
            end
          end
          BODY: begin
            cnt <= cnt_nxt;
            ovf <= ovf_nxt;
            if (commit) begin
              commit_ptr <= wr_ptr + {{AW{1'b0}}, wr_ok};
              state      <= IDLE;
            end else if (drop_eop) begin
              wr_ptr <= pkt_start_ptr;
              state  <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // The word that completes the declared length carries the last flag; any
  // extra word makes the count mismatch, so a stale flag is never committed.
  ingress_sram #(
    .DEPTH     (DEPTH),
    .WIDTH     (DATA_WIDTH + 1),
    .ADDR_BITS (AW)
  ) u_sram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr[AW-1:0]),
    .wdata ({word_last, wr_data}),
    .re    (rd_acc),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (sram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_acc;
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  assign rd_vld  = rd_vld_q;
  assign rd_data = rd_vld_q ? sram_q[DATA_WIDTH-1:0] : '0;
  assign rd_last = rd_vld_q & sram_q[DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (commit) desc_mem[desc_wp[DAW-1:0]] <= {hdr_len, hdr_prio, hdr_dest};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      desc_wp <= '0;
      desc_rp <= '0;
    end else begin
      if (commit)   desc_wp <= desc_wp + (DAW+1)'(1);
      if (desc_pop) desc_rp <= desc_rp + (DAW+1)'(1);
    end
  end

  assign desc_head = desc_mem[desc_rp[DAW-1:0]];
  assign desc_len  = desc_vld ? desc_head[PORT_BITS+PRIO_BITS +: LEN_BITS] : '0;
  assign desc_prio = desc_vld ? desc_head[PORT_BITS +: PRIO_BITS] : '0;
  assign desc_dest = desc_vld ? desc_head[PORT_BITS-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pause <= 1'b0;
    end else begin
      pause <= (free_words < THRESH_P) || (desc_cnt >= DESC_HI);
    end
  end

`ifdef INGRESS_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkt  <= '0;
      stat_drop <= '0;
    end else begin
      if (commit)             stat_pkt  <= sat_inc(stat_pkt);
      if (abort || drop_eop)  stat_drop <= sat_inc(stat_drop);
    end
  end
`endif

endmodule

// File: tb/tb_ingress_port_buffer.sv
// Randomised scoreboard bench for ingress_port_buffer (DEPTH=64, PAUSE_THRESH=8).
module tb_ingress_port_buffer;

  localparam int DW          = 16;
  localparam int DEPTH       = 64;
  localparam int DESC_DEPTH  = 16;
  localparam int PAUSE_TH    = 8;
  localparam int MAXLEN      = 511;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_sop, wr_vld, wr_eop;
  logic [DW-1:0] wr_data;
  logic          pause, desc_vld, desc_rdy;
  logic [3:0]    desc_dest;
  logic [2:0]    desc_prio;
  logic [8:0]    desc_len;
  logic          rd_req, rd_vld, rd_last;
  logic [DW-1:0] rd_data;
  logic [1:0]    fsm_state;
`ifdef INGRESS_STATS_EN
  logic [31:0]   stat_pkt, stat_drop;
`endif

  always #5 clk = ~clk;

  ingress_port_buffer #(
    .DATA_WIDTH(DW), .PORT_BITS(4), .PRIO_BITS(3), .LEN_BITS(9),
    .DEPTH(DEPTH), .DESC_DEPTH(DESC_DEPTH), .PAUSE_THRESH(PAUSE_TH)
  ) dut (
    .clk(clk), .rst(rst), .wr_sop(wr_sop), .wr_vld(wr_vld), .wr_eop(wr_eop),
    .wr_data(wr_data), .pause(pause), .desc_vld(desc_vld), .desc_rdy(desc_rdy),
    .desc_dest(desc_dest), .desc_prio(desc_prio), .desc_len(desc_len),
    .rd_req(rd_req), .rd_vld(rd_vld), .rd_data(rd_data), .rd_last(rd_last),
    .fsm_state(fsm_state)
`ifdef INGRESS_STATS_EN
    , .stat_pkt(stat_pkt), .stat_drop(stat_drop)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Expected outputs: payload words as {last, data}, descriptors as {len, prio, dest}.
  logic [DW:0]   exp_q[$];
  logic [15:0]   desc_exp_q[$];

  // Reference model of the packet rules.
  logic [DW-1:0] part_q[$];
  int            unread;
  int            desc_cnt;
  bit            in_pkt;
  int            m_len;
  logic [15:0]   m_hdr;
  bit            m_ovf;
  int            m_pkts;
  int            m_drops;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void m_reset();
    exp_q.delete(); desc_exp_q.delete(); part_q.delete();
    unread = 0; desc_cnt = 0; in_pkt = 0; m_ovf = 0; m_len = 0;
    m_pkts = 0; m_drops = 0;
  endfunction

  function automatic void m_sop();
    if (in_pkt) m_drops++;
    part_q.delete();
    in_pkt = 1;
  endfunction

  function automatic void m_header(input logic [15:0] h);
    m_hdr = h;
    m_len = int'(h[15:7]);
    m_ovf = 0;
    part_q.delete();
  endfunction

  function automatic void m_word(input logic [DW-1:0] d);
    if (unread + part_q.size() == DEPTH || part_q.size() == MAXLEN) m_ovf = 1;
    else part_q.push_back(d);
  endfunction

  function automatic void m_eop();
    if (part_q.size() == m_len && !m_ovf && desc_cnt < DESC_DEPTH) begin
      for (int i = 0; i < m_len; i++) exp_q.push_back({(i == m_len - 1), part_q[i]});
      desc_exp_q.push_back(m_hdr);
      desc_cnt++;
      unread += m_len;
      m_pkts++;
    end else begin
      m_drops++;
    end
    part_q.delete();
    in_pkt = 0;
  endfunction

  function automatic bit exp_pause();
    return ((DEPTH - (unread + part_q.size())) < PAUSE_TH) || (desc_cnt >= DESC_DEPTH - 1);
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a word or a descriptor.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (rd_vld) begin
        if (exp_q.size() == 0) check("rd_unexpected", {rd_last, rd_data}, 32'hdead);
        else check("rd_word", {rd_last, rd_data}, exp_q.pop_front());
      end
      if (desc_vld && desc_rdy) begin
        if (desc_exp_q.size() == 0) check("desc_unexpected", {desc_len, desc_prio, desc_dest}, 32'hdead);
        else check("desc", {desc_len, desc_prio, desc_dest}, desc_exp_q.pop_front());
        desc_cnt--;
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    wr_sop = 0; wr_vld = 0; wr_eop = 0;
    repeat (n) cyc();
  endtask

  task automatic send_pkt(input int len, input int nwords, input bit do_eop,
                          input int dest, input int prio);
    logic [15:0] h;
    bit          eop_done;
    h = {9'(len), 3'(prio), 4'(dest)};
    wr_sop = 1; wr_vld = 0; wr_eop = 0; m_sop(); cyc();
    wr_sop = 0; wr_vld = 1; wr_data = h; m_header(h); cyc();
    eop_done = 0;
    for (int i = 0; i < nwords; i++) begin
      wr_vld = 0;
      repeat ($urandom_range(0, 1)) cyc();
      wr_vld = 1;
      wr_data = DW'($urandom);
      m_word(wr_data);
      if (do_eop && i == nwords - 1 && $urandom_range(0, 1) == 1) begin
        wr_eop = 1; eop_done = 1;
      end
      cyc();
    end
    wr_vld = 0; wr_eop = 0;
    if (do_eop && !eop_done) begin
      wr_eop = 1; cyc();
    end
    if (do_eop) m_eop();
    wr_eop = 0; wr_vld = 0;
  endtask

  task automatic hdr_eop_pkt(input int len);
    wr_sop = 1; wr_vld = 0; wr_eop = 0; m_sop(); cyc();
    wr_sop = 0; wr_vld = 1; wr_eop = 1; wr_data = {9'(len), 3'd1, 4'd2}; cyc();
    m_drops++; in_pkt = 0;
    wr_vld = 0; wr_eop = 0;
  endtask

  task automatic check_pause(input string name);
    idle(2);
    @(negedge clk);
    check(name, pause, exp_pause());
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 3000;
    while ((exp_q.size() > 0 || desc_exp_q.size() > 0) && budget > 0) begin
      rd_req   = (unread > 0) && ($urandom_range(0, 3) != 0);
      if (rd_req) unread--;
      desc_rdy = ($urandom_range(0, 2) != 0);
      cyc();
      budget--;
    end
    rd_req = 0; desc_rdy = 0;
    if (budget == 0) begin
      check({name, "_timeout"}, exp_q.size() + desc_exp_q.size(), 0);
      exp_q.delete(); desc_exp_q.delete();
    end
    idle(2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    m_reset();
    rst = 1; wr_sop = 0; wr_vld = 0; wr_eop = 0; wr_data = '0;
    rd_req = 0; desc_rdy = 0;
    repeat (3) cyc();
    rst = 0;
    @(negedge clk);
    check("rst_pause", pause, 0);
    check("rst_desc_vld", desc_vld, 0);
    check("rst_rd_vld", rd_vld, 0);
    check("rst_desc_len", desc_len, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_state", fsm_state, 0);
`ifdef INGRESS_STATS_EN
    check("rst_stat_pkt", stat_pkt, 0);
    check("rst_stat_drop", stat_drop, 0);
`endif
    @(posedge clk); #1;

    // A: good 31-word packet.
    send_pkt(31, 31, 1, 3, 4);
    idle(1);
    @(negedge clk);
    check("a_desc_vld", desc_vld, 1);
    check("a_desc_dest", desc_dest, 3);
    check("a_desc_prio", desc_prio, 4);
    check("a_desc_len", desc_len, 31);
    @(posedge clk); #1;
    drain("a_drain");

    // B: length mismatch is dropped; nothing readable.
    send_pkt(34, 31, 1, 5, 1);
    idle(1);
    @(negedge clk);
    check("b_desc_vld", desc_vld, 0);
    @(posedge clk); #1;
    rd_req = 1; cyc(); rd_req = 0;
    @(negedge clk);
    check("b_no_rd_vld", rd_vld, 0);
    @(posedge clk); #1;
    check_pause("b_pause");

    // C: sop mid-body aborts the first packet.
    send_pkt(20, 10, 0, 1, 2);
    send_pkt(5, 5, 1, 7, 6);
    drain("c_drain");

    // D: pause threshold and buffer overflow.
    send_pkt(56, 56, 1, 2, 2);
    check_pause("d_pause_56");
    send_pkt(1, 1, 1, 2, 3);
    check_pause("d_pause_57");
    send_pkt(70, 70, 1, 4, 0);
    check_pause("d_pause_after_ovf");
    drain("d_drain1");
    send_pkt(4, 4, 1, 9, 5);
    drain("d_drain2");
    check_pause("d_pause_empty");

    // E: descriptor FIFO fills with desc_rdy low.
    for (int i = 0; i < 17; i++) begin
      send_pkt(1, 1, 1, i % 16, i % 8);
      if (i == 14) check_pause("e_pause_15");
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("e_stable", {desc_vld, desc_len, desc_prio, desc_dest}, {1'b1, desc_exp_q[0]});
    end
    @(posedge clk); #1;
    drain("e_drain");

    // F: reset mid-body while a descriptor is pending.
    send_pkt(3, 3, 1, 6, 6);
    idle(1);
    @(negedge clk);
    check("f_desc_vld_pre", desc_vld, 1);
    @(posedge clk); #1;
    send_pkt(6, 4, 0, 8, 1);
    rst = 1; cyc(); rst = 0;
    m_reset();
    @(negedge clk);
    check("f_desc_vld", desc_vld, 0);
    check("f_pause", pause, 0);
    check("f_rd_vld", rd_vld, 0);
`ifdef INGRESS_STATS_EN
    check("f_stat_pkt", stat_pkt, 0);
    check("f_stat_drop", stat_drop, 0);
`endif
    @(posedge clk); #1;
    send_pkt(4, 4, 1, 10, 7);
    drain("f_drain");

    // G: random mix of good, short/long, aborted, header-only and empty packets.
    for (int n = 0; n < 30; n++) begin
      int len, mode;
      len  = $urandom_range(0, 10);
      mode = $urandom_range(0, 9);
      case (mode)
        6:       send_pkt(len, len + 1, 1, $urandom_range(0, 15), $urandom_range(0, 7));
        7:       send_pkt(len, $urandom_range(0, 6), 0, $urandom_range(0, 15), $urandom_range(0, 7));
        8:       hdr_eop_pkt(len);
        default: send_pkt(len, len, 1, $urandom_range(0, 15), $urandom_range(0, 7));
      endcase
      if (n % 5 == 4) begin
        check_pause("g_pause");
        drain("g_drain");
      end
    end
    send_pkt(0, 0, 1, 12, 3);
    drain("g_final_drain");
    check_pause("g_pause_end");
`ifdef INGRESS_STATS_EN
    check("g_stat_pkt", stat_pkt, m_pkts);
    check("g_stat_drop", stat_drop, m_drops);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ingress_port_buffer.md
Name: ingress_port_buffer

Overview:
Parametrised per-port ingress front-end for the hydra switch. Accepts the wr_sop/wr_vld/wr_eop packet stream and parses the header word {len, prio, dest}. Buffers the payload in a circular SRAM and commits only complete, length-correct packets. Presents one descriptor per committed packet plus a 1-cycle-latency word read port to the switch core. Asserts pause as backpressure.

Parameters:
DATA_WIDTH, 16, data word width; must be ≥ LEN_BITS+PRIO_BITS+PORT_BITS
PORT_BITS, 4, dest field width (header bits [PORT_BITS-1:0])
PRIO_BITS, 3, prio field width (next bits up)
LEN_BITS, 9, payload-length field width (next bits up)
DEPTH, 512, data buffer words (power of 2)
DESC_DEPTH, 16, descriptor FIFO entries (power of 2)
PAUSE_THRESH, 64, pause when free words < this

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wr_sop  in  1  packet start strobe
wr_vld  in  1  data word valid
wr_eop  in  1  packet end strobe
wr_data  in  DATA_WIDTH  header/payload word
pause  out  1  backpressure to source (registered)
desc_vld  out  1  descriptor available
desc_rdy  in  1  descriptor consumed when desc_vld&&desc_rdy
desc_dest  out  PORT_BITS  destination port
desc_prio  out  PRIO_BITS  priority
desc_len  out  LEN_BITS  payload words
rd_req  in  1  read next committed word
rd_vld  out  1  word valid, 1 cycle after accepted rd_req
rd_data  out  DATA_WIDTH  payload word
rd_last  out  1  last payload word of packet

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high. All pointers, counters and the FSM clear on reset. Outputs reset to 0, except pause=0 and desc_vld=0.
- Reset mid-packet discards all stored and partial data; no descriptor is emitted for it.
- FSM IDLE→HDR on wr_sop. Data and vld in the sop cycle are ignored.
- HDR: first wr_vld word is the header. Latch dest/prio/len, clear payload count, go to BODY. Header is not stored.
- BODY: each wr_vld writes wr_data at wr_ptr and increments count.
- wr_eop (in HDR or BODY) ends the packet. A wr_vld in the same cycle as eop is included.
  - eop in HDR: packet dropped.
  - eop in BODY: commit if count==len and no overflow, otherwise drop.
- Commit: commit_ptr←wr_ptr; last word marked; descriptor pushed; FSM→IDLE.
- Drop: wr_ptr←pkt_start_ptr (rollback); no descriptor; FSM→IDLE.
- len=0 packet: header then eop → commit with zero words. Descriptor pushed, rd_last never seen for it.
- wr_sop while in HDR/BODY: abort current packet (rollback), start new one in HDR.
- Overflow: wr_vld when buffer full (wr_ptr-rd_ptr==DEPTH) or count would exceed 2^LEN_BITS-1. Word not written; packet flagged for drop at eop.
- Commit while descriptor FIFO full: drop.
- pause registered: 1 when (DEPTH-used) < PAUSE_THRESH, or desc FIFO holds DESC_DEPTH-1 or more entries. Source may overshoot; overflow rule covers it.
- Read side: rd_req is accepted only when rd_ptr != commit_ptr; otherwise it is ignored with no rd_vld.
  - Accepted read: next cycle rd_vld=1 with rd_data/rd_last, rd_ptr++.
  - Reads may be back-to-back and may cross packet boundaries; the core pairs them with descriptors.
- desc_* are stable while desc_vld && !desc_rdy. Pop on handshake.
- Pointers are log2(DEPTH)+1 bits with wrap bit; full/empty by wrap compare.
- Simultaneous commit and read in the same cycle are both legal.

Optional Feature:
INGRESS_STATS_EN: when defined, adds outputs stat_pkt (32b, committed packets) and stat_drop (32b, dropped/aborted packets).
- Both saturate at all-ones and clear on rst.
- When undefined, neither port nor logic exists.

Decomposition:
- Package hydra_pkg: header field widths, typedef hdr_t {len, prio, dest}, typedef desc_t, FSM state enum (IDLE, HDR, BODY).
- One sub-module: ingress_sram. Simple dual-port, DEPTH x (DATA_WIDTH+1), registered read, 1-cycle latency.

Test Plan:
- Header {9'd31,3'd4,4'd3}, 31 payload words, eop → desc dest=3 prio=4 len=31. 31 reads return the words in order; rd_last only on the 31st.
- Header len=34 with 31 payload words then eop → dropped. No desc_vld; rd_req yields no rd_vld; buffer free space restored.
- wr_sop mid-body (10 words) then full 5-word packet len=5 → only the second descriptor; reads return its 5 words.
- DEPTH=64, PAUSE_THRESH=8 with no reads: pause rises once 57 words are used. A 70-word packet is dropped; the next 4-word packet commits after space is freed.
- Hold desc_rdy=0 and commit 15 packets (DESC_DEPTH=16) → pause=1 from the 15th commit. A 17th commit is dropped; desc_* stay stable.
- rst asserted mid-body and while desc_vld=1 → next cycle desc_vld=0, pause=0, stats (INGRESS_STATS_EN) = 0; a following packet commits normally.
